// File: rtl/dmux_pkg.sv
// Shared constants, lane state encoding and lane bit-offset helper for the
// 8-way 16-bit demultiplexing distributor.
package dmux_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

  // Bit offset of lane k inside the packed out_data bus.
  function automatic int lane_slice(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/dmux_lane_reg.sv
// One-entry holding register with a valid/ready read side. The writer only
// asserts wr_en when the lane is empty or being drained in the same cycle.
module dmux_lane_reg
  import dmux_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  lane_state_e      state_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LANE_EMPTY;
      data_q  <= '0;
    end else begin
      case (state_q)
        LANE_EMPTY: begin
          if (wr_en) begin
            state_q <= LANE_FULL;
            data_q  <= wr_data;
          end
        end
        LANE_FULL: begin
          // A write in the drain cycle reloads; data is frozen while stalled.
          if (wr_en) begin
            data_q <= wr_data;
          end else if (rd_ready) begin
            state_q <= LANE_EMPTY;
          end
        end
        default: state_q <= LANE_EMPTY;
      endcase
    end
  end

  assign valid = (state_q == LANE_FULL);
  assign data  = data_q;

endmodule

// File: rtl/dmux8way16_dist.sv
// Registered 1-to-8 distributor: select decode, all-or-nothing broadcast and
// in_ready steering in front of eight independent holding registers.
module dmux8way16_dist
  import dmux_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   busy
);

  logic [LANES-1:0] lane_free;
  logic [LANES-1:0] lane_wr;
  logic             accept;

  // A lane being drained this cycle can take a new word in the same cycle.
  assign lane_free = ~out_valid | out_ready;
  assign in_ready  = in_bcast ? (&lane_free) : lane_free[in_sel];
  assign accept    = in_valid & in_ready;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_wr[gi] = accept & (in_bcast | (in_sel == SEL_W'(gi)));

      dmux_lane_reg #(
        .WIDTH(WIDTH)
      ) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (lane_wr[gi]),
        .wr_data (in_data),
        .rd_ready(out_ready[gi]),
        .valid   (out_valid[gi]),
        .data    (out_data[lane_slice(gi, WIDTH) +: WIDTH])
      );
    end
  endgenerate

  assign busy = |out_valid;

endmodule

// File: tb/tb_dmux8way16_dist.sv
// Directed bench: accepts push expected words into a scoreboard; a monitor
// pops and compares each word as a consumer takes it from its lane.
module tb_dmux8way16_dist;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic [2:0]   in_sel;
  logic         in_bcast;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          lane;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  dmux8way16_dist #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_bcast (in_bcast),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [15:0] lane_of(input int k);
    return out_data[k*16 +: 16];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one input beat; check in_ready against the hand-derived value and
  // record the expected word(s) if the beat is to be accepted.
  task automatic send(input string name, input logic [2:0] sel, input logic bc,
                      input logic [15:0] d, input logic exp_rdy);
    exp_t e;
    in_valid = 1'b1;
    in_sel   = sel;
    in_bcast = bc;
    in_data  = d;
    #1;
    check({name, " in_ready"}, {127'd0, in_ready}, {127'd0, exp_rdy});
    if (exp_rdy) begin
      for (int k = 0; k < 8; k++) begin
        if (bc || sel == 3'(k)) begin
          e.lane = k;
          e.data = d;
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_bcast = 1'b0;
  endtask

  // Monitor: a consumer handshake seen at the falling edge completes at the
  // next rising edge, since the bench only changes inputs just after rising.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 8; k++) begin
          if (out_valid[k] && out_ready[k]) begin
            int idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
              if (sb[i].lane == k) begin
                idx = i;
                break;
              end
            end
            checks++;
            if (idx < 0) begin
              errors++;
              $display("FAIL consume lane%0d: got %h expected no word", k, lane_of(k));
            end else begin
              if (lane_of(k) !== sb[idx].data) begin
                errors++;
                $display("FAIL consume lane%0d: got %h expected %h", k, lane_of(k), sb[idx].data);
              end else begin
                $display("ok   consume lane%0d: %h", k, lane_of(k));
              end
              sb.delete(idx);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_bcast  = 1'b0;
    out_ready = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("reset out_valid", {120'd0, out_valid}, 128'd0);
    check("reset out_data", out_data, 128'd0);
    check("reset busy", {127'd0, busy}, 128'd0);
    check("reset in_ready", {127'd0, in_ready}, 128'd1);

    // Single route to lane 5.
    send("route5", 3'd5, 1'b0, 16'hBEEF, 1'b1);
    step();
    idle();
    check("route5 out_valid", {120'd0, out_valid}, {120'd0, 8'b0010_0000});
    check("route5 out_data", out_data, {32'd0, 16'hBEEF, 80'd0});
    check("route5 busy", {127'd0, busy}, 128'd1);
    out_ready = 8'h20;
    step();
    out_ready = 8'h00;
    check("route5 drained", {120'd0, out_valid}, 128'd0);

    // Back-pressure on lane 2.
    send("bp load", 3'd2, 1'b0, 16'h1111, 1'b1);
    step();
    send("bp stall", 3'd2, 1'b0, 16'h1234, 1'b0);
    step();
    check("bp held data", {112'd0, lane_of(2)}, {112'd0, 16'h1111});
    check("bp held valid", {120'd0, out_valid}, {120'd0, 8'h04});
    out_ready = 8'h04;
    send("bp release", 3'd2, 1'b0, 16'h1234, 1'b1);
    step();
    idle();
    check("bp reload data", {112'd0, lane_of(2)}, {112'd0, 16'h1234});
    check("bp reload valid", {120'd0, out_valid}, {120'd0, 8'h04});
    step();
    out_ready = 8'h00;
    check("bp drained", {120'd0, out_valid}, 128'd0);

    // Streaming one word per lane on consecutive cycles.
    out_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      send($sformatf("stream%0d", i), 3'(i), 1'b0, 16'(i), 1'b1);
      step();
      check($sformatf("stream%0d data", i), {112'd0, lane_of(i)}, {112'd0, 16'(i)});
      check($sformatf("stream%0d valid", i), {127'd0, out_valid[i]}, 128'd1);
    end
    idle();
    step();
    out_ready = 8'h00;
    check("stream drained", {120'd0, out_valid}, 128'd0);

    // Broadcast stalls while lane 7 is full and stalled.
    send("bc load7", 3'd7, 1'b0, 16'h7777, 1'b1);
    step();
    send("bc stall", 3'd3, 1'b1, 16'hA5A5, 1'b0);
    step();
    check("bc stall valid", {120'd0, out_valid}, {120'd0, 8'h80});
    check("bc stall data7", {112'd0, lane_of(7)}, {112'd0, 16'h7777});
    out_ready = 8'h80;
    send("bc release", 3'd1, 1'b1, 16'hA5A5, 1'b1);
    step();
    idle();
    out_ready = 8'h00;
    check("bc all valid", {120'd0, out_valid}, {120'd0, 8'hFF});
    check("bc all data", out_data, {8{16'hA5A5}});
    out_ready = 8'hFF;
    step();
    out_ready = 8'h00;
    check("bc drained", {120'd0, out_valid}, 128'd0);

    // Independent lanes: lane 3 stalled does not block lane 4.
    send("ind load3", 3'd3, 1'b0, 16'h3333, 1'b1);
    step();
    send("ind send4", 3'd4, 1'b0, 16'h0F0F, 1'b1);
    step();
    idle();
    check("ind valid", {120'd0, out_valid}, {120'd0, 8'h18});
    check("ind data3", {112'd0, lane_of(3)}, {112'd0, 16'h3333});
    check("ind data4", {112'd0, lane_of(4)}, {112'd0, 16'h0F0F});
    out_ready = 8'hFF;
    step();
    out_ready = 8'h00;

    // Asynchronous reset while lanes 0, 1 and 6 hold words.
    send("ar load0", 3'd0, 1'b0, 16'hA000, 1'b1);
    step();
    send("ar load1", 3'd1, 1'b0, 16'hA001, 1'b1);
    step();
    send("ar load6", 3'd6, 1'b0, 16'hA006, 1'b1);
    step();
    idle();
    check("ar pre valid", {120'd0, out_valid}, {120'd0, 8'h43});
    #2;
    rst_n = 1'b0;
    #1;
    check("ar out_valid", {120'd0, out_valid}, 128'd0);
    check("ar out_data", out_data, 128'd0);
    check("ar busy", {127'd0, busy}, 128'd0);
    sb.delete();
    step();
    rst_n = 1'b1;
    in_bcast = 1'b1;
    #1;
    check("ar post in_ready bcast", {127'd0, in_ready}, 128'd1);
    in_bcast = 1'b0;
    in_sel   = 3'd6;
    #1;
    check("ar post in_ready sel6", {127'd0, in_ready}, 128'd1);
    step();
    check("scoreboard empty", 128'(sb.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
